// File: rtl/core_pkg.sv
// Shared core definitions: decoder control bundle, forwarding selects and
// the pipeline stage records carried between EX, MEM and WB.
package core_pkg;

  typedef struct packed {
    logic       ALUSrc;
    logic       MemtoReg;
    logic       RegWrite;
    logic       MemRead;
    logic       MemWrite;
    logic [1:0] ALUOp;
    logic       Branch;
    logic       JalSel;
    logic       JalrSel;
  } ctrl_t;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  localparam int REG_W = 5;
  localparam int NUM_OPS = 2;

  // EX keeps source indices for forwarding; later stages only need rd.
  typedef struct packed {
    logic             valid;
    ctrl_t            ctrl;
    logic [REG_W-1:0] rs1;
    logic [REG_W-1:0] rs2;
    logic [REG_W-1:0] rd;
  } ex_stage_t;

  typedef struct packed {
    logic             valid;
    ctrl_t            ctrl;
    logic [REG_W-1:0] rd;
  } rd_stage_t;

endpackage

// File: rtl/hazard_unit.sv
// Combinational hazard detection: load-use stall, control-transfer flush and
// per-operand forwarding select for the instruction sitting in EX.
module hazard_unit
  import core_pkg::*;
(
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             ex_valid,
  input  logic             ex_mem_read,
  input  logic             ex_jal,
  input  logic             ex_branch,
  input  logic             ex_branch_taken,
  input  logic [REG_W-1:0] ex_rd,
  input  logic [REG_W-1:0] ex_rs1,
  input  logic [REG_W-1:0] ex_rs2,
  input  logic             mem_valid,
  input  logic             mem_reg_write,
  input  logic             mem_mem_read,
  input  logic [REG_W-1:0] mem_rd,
  input  logic             wb_valid,
  input  logic             wb_reg_write,
  input  logic [REG_W-1:0] wb_rd,
  output logic             stall,
  output logic             flush,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b
);

  logic load_use;
  logic [NUM_OPS-1:0][REG_W-1:0] op_rs;
  logic [NUM_OPS-1:0][1:0]       op_fwd;

  assign flush    = ex_valid & (ex_jal | (ex_branch & ex_branch_taken));
  assign load_use = id_valid & ex_valid & ex_mem_read & (ex_rd != '0) &
                    ((ex_rd == id_rs1) | (ex_rd == id_rs2));
  // A taken transfer squashes the ID instruction, so its hazard is moot.
  assign stall    = load_use & ~flush;

  assign op_rs[0] = ex_rs1;
  assign op_rs[1] = ex_rs2;

  for (genvar op = 0; op < NUM_OPS; op++) begin : g_fwd
    logic mem_hit, wb_hit;
    // Load data is not ready in MEM; the stall lets WB supply it instead.
    assign mem_hit = mem_valid & mem_reg_write & ~mem_mem_read &
                     (mem_rd != '0) & (mem_rd == op_rs[op]);
    assign wb_hit  = wb_valid & wb_reg_write &
                     (wb_rd != '0) & (wb_rd == op_rs[op]);
    assign op_fwd[op] = mem_hit ? FWD_MEM : (wb_hit ? FWD_WB : FWD_RF);
  end

  assign fwd_a = op_fwd[0];
  assign fwd_b = op_fwd[1];

endmodule

// File: rtl/ctrl_pipe.sv
// Control-side pipeline: EX/MEM/WB control registers, bubble insertion on
// stall or flush, and saturating stall/flush event counters.
module ctrl_pipe
  import core_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  ctrl_t            id_ctrl,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic [REG_W-1:0] id_rd,
  input  logic             ex_branch_taken,
  output logic             stall,
  output logic             flush,
  output ctrl_t            ex_ctrl,
  output ctrl_t            mem_ctrl,
  output ctrl_t            wb_ctrl,
  output logic             ex_valid,
  output logic             mem_valid,
  output logic             wb_valid,
  output logic [REG_W-1:0] ex_rd,
  output logic [REG_W-1:0] mem_rd,
  output logic [REG_W-1:0] wb_rd,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  ex_stage_t        ex_q, ex_d;
  rd_stage_t        mem_q, mem_d, wb_q, wb_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;

  hazard_unit u_hazard (
    .id_valid        (id_valid),
    .id_rs1          (id_rs1),
    .id_rs2          (id_rs2),
    .ex_valid        (ex_q.valid),
    .ex_mem_read     (ex_q.ctrl.MemRead),
    .ex_jal          (ex_q.ctrl.JalSel),
    .ex_branch       (ex_q.ctrl.Branch),
    .ex_branch_taken (ex_branch_taken),
    .ex_rd           (ex_q.rd),
    .ex_rs1          (ex_q.rs1),
    .ex_rs2          (ex_q.rs2),
    .mem_valid       (mem_q.valid),
    .mem_reg_write   (mem_q.ctrl.RegWrite),
    .mem_mem_read    (mem_q.ctrl.MemRead),
    .mem_rd          (mem_q.rd),
    .wb_valid        (wb_q.valid),
    .wb_reg_write    (wb_q.ctrl.RegWrite),
    .wb_rd           (wb_q.rd),
    .stall           (stall),
    .flush           (flush),
    .fwd_a           (fwd_a),
    .fwd_b           (fwd_b)
  );

  always_comb begin
    ex_d = '0;
    if (id_valid && !stall && !flush) begin
      ex_d.valid = 1'b1;
      ex_d.ctrl  = id_ctrl;
      ex_d.rs1   = id_rs1;
      ex_d.rs2   = id_rs2;
      ex_d.rd    = id_rd;
    end
    // MEM and WB always drain, even while ID is held or squashed.
    mem_d.valid = ex_q.valid;
    mem_d.ctrl  = ex_q.ctrl;
    mem_d.rd    = ex_q.rd;
    wb_d        = mem_q;

    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
    if (flush && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ex_q        <= '0;
      mem_q       <= '0;
      wb_q        <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      ex_q        <= ex_d;
      mem_q       <= mem_d;
      wb_q        <= wb_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign ex_valid  = ex_q.valid;
  assign ex_ctrl   = ex_q.ctrl;
  assign ex_rd     = ex_q.rd;
  assign mem_valid = mem_q.valid;
  assign mem_ctrl  = mem_q.ctrl;
  assign mem_rd    = mem_q.rd;
  assign wb_valid  = wb_q.valid;
  assign wb_ctrl   = wb_q.ctrl;
  assign wb_rd     = wb_q.rd;
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_ctrl_pipe.sv
// Directed scenarios plus a WB scoreboard for ctrl_pipe; a second instance
// with 2-bit counters exercises saturation.
module tb_ctrl_pipe;
  import core_pkg::*;

  localparam ctrl_t C_LW   = 10'b1111000000;
  localparam ctrl_t C_ADD  = 10'b0010010000;
  localparam ctrl_t C_ADDI = 10'b1010010000;
  localparam ctrl_t C_BEQ  = 10'b0000001100;
  localparam ctrl_t C_JLD  = 10'b0011000010;

  typedef struct packed { ctrl_t ctrl; logic [4:0] rd; } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  logic id_valid, ex_branch_taken;
  ctrl_t id_ctrl;
  logic [4:0] id_rs1, id_rs2, id_rd;

  logic stall, flush, ex_valid, mem_valid, wb_valid;
  ctrl_t ex_ctrl, mem_ctrl, wb_ctrl;
  logic [4:0] ex_rd, mem_rd, wb_rd;
  logic [1:0] fwd_a, fwd_b;
  logic [15:0] stall_cnt, flush_cnt;

  logic s_stall, s_flush, s_ex_valid, s_mem_valid, s_wb_valid;
  ctrl_t s_ex_ctrl, s_mem_ctrl, s_wb_ctrl;
  logic [4:0] s_ex_rd, s_mem_rd, s_wb_rd;
  logic [1:0] s_fwd_a, s_fwd_b;
  logic [1:0] s_stall_cnt, s_flush_cnt;

  int vectors = 0;
  int miscompares = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  ctrl_pipe u_dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_ctrl(id_ctrl),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .ex_branch_taken(ex_branch_taken),
    .stall(stall), .flush(flush), .ex_ctrl(ex_ctrl), .mem_ctrl(mem_ctrl), .wb_ctrl(wb_ctrl),
    .ex_valid(ex_valid), .mem_valid(mem_valid), .wb_valid(wb_valid),
    .ex_rd(ex_rd), .mem_rd(mem_rd), .wb_rd(wb_rd), .fwd_a(fwd_a), .fwd_b(fwd_b),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  ctrl_pipe #(.CNT_W(2)) u_sat (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_ctrl(id_ctrl),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .ex_branch_taken(ex_branch_taken),
    .stall(s_stall), .flush(s_flush), .ex_ctrl(s_ex_ctrl), .mem_ctrl(s_mem_ctrl), .wb_ctrl(s_wb_ctrl),
    .ex_valid(s_ex_valid), .mem_valid(s_mem_valid), .wb_valid(s_wb_valid),
    .ex_rd(s_ex_rd), .mem_rd(s_mem_rd), .wb_rd(s_wb_rd), .fwd_a(s_fwd_a), .fwd_b(s_fwd_b),
    .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
  );

  // Scoreboard: every accepted instruction must retire through WB in order.
  always @(negedge clk) begin
    if (wb_valid === 1'b1) begin
      vectors++;
      if (sb.size() == 0) begin
        miscompares++;
        $display("FAIL wb_unexpected: got ctrl=%b rd=%0d, none expected", wb_ctrl, wb_rd);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if ({wb_ctrl, wb_rd} !== {e.ctrl, e.rd}) begin
          miscompares++;
          $display("FAIL wb_retire: got ctrl=%b rd=%0d, want ctrl=%b rd=%0d",
                   wb_ctrl, wb_rd, e.ctrl, e.rd);
        end
      end
    end
  end

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic drive(input logic v, input ctrl_t c, input logic [4:0] r1, r2, d);
    id_valid = v; id_ctrl = c; id_rs1 = r1; id_rs2 = r2; id_rd = d;
  endtask

  task automatic push(input ctrl_t c, input logic [4:0] d);
    exp_t e;
    e.ctrl = c; e.rd = d;
    sb.push_back(e);
  endtask

  task automatic drain;
    drive(1'b0, '0, 5'd0, 5'd0, 5'd0);
    ex_branch_taken = 1'b0;
    repeat (4) tick();
  endtask

  function automatic logic [1:0] exp_fwd(input logic [4:0] rs,
                                         input logic mem_ok, input logic mem_rw, input logic [4:0] mem_d,
                                         input logic wb_ok, input logic wb_rw, input logic [4:0] wb_d);
    if (mem_ok && mem_rw && mem_d != 0 && mem_d == rs) return 2'b10;
    if (wb_ok && wb_rw && wb_d != 0 && wb_d == rs) return 2'b01;
    return 2'b00;
  endfunction

  task automatic test_reset;
    rst_n = 1'b0;
    ex_branch_taken = 1'b0;
    drive(1'b1, C_LW, 5'd5, 5'd5, 5'd5);
    repeat (2) tick();
    vectors++; if (ex_valid !== 1'b0) begin miscompares++; $display("FAIL rst_ex_valid: got %b want 0", ex_valid); end
    vectors++; if (mem_valid !== 1'b0) begin miscompares++; $display("FAIL rst_mem_valid: got %b want 0", mem_valid); end
    vectors++; if (wb_valid !== 1'b0) begin miscompares++; $display("FAIL rst_wb_valid: got %b want 0", wb_valid); end
    vectors++; if ({stall, flush} !== 2'b00) begin miscompares++; $display("FAIL rst_stall_flush: got %b want 00", {stall, flush}); end
    vectors++; if ({fwd_a, fwd_b} !== 4'b0000) begin miscompares++; $display("FAIL rst_fwd: got %b want 0000", {fwd_a, fwd_b}); end
    vectors++; if ({stall_cnt, flush_cnt} !== 32'd0) begin miscompares++; $display("FAIL rst_cnt: got %0d/%0d want 0/0", stall_cnt, flush_cnt); end
    rst_n = 1'b1;
    drive(1'b0, '0, 5'd0, 5'd0, 5'd0);
    tick();
    vectors++; if ({stall, flush, ex_valid} !== 3'b000) begin miscompares++; $display("FAIL post_rst: got %b want 000", {stall, flush, ex_valid}); end
    sb.delete();
  endtask

  task automatic test_load_use;
    drive(1'b1, C_LW, 5'd2, 5'd0, 5'd5); push(C_LW, 5'd5);
    #1;
    vectors++; if (stall !== 1'b0) begin miscompares++; $display("FAIL lu_no_stall: got %b want 0", stall); end
    tick();
    drive(1'b1, C_ADD, 5'd5, 5'd1, 5'd6);
    #1;
    vectors++; if ({stall, flush} !== 2'b10) begin miscompares++; $display("FAIL lu_stall: got %b want 10", {stall, flush}); end
    tick();
    vectors++; if (ex_valid !== 1'b0) begin miscompares++; $display("FAIL lu_bubble: got %b want 0", ex_valid); end
    vectors++; if (stall !== 1'b0) begin miscompares++; $display("FAIL lu_one_cycle: got %b want 0", stall); end
    vectors++; if (stall_cnt !== 16'd1) begin miscompares++; $display("FAIL lu_cnt: got %0d want 1", stall_cnt); end
    push(C_ADD, 5'd6);
    tick();
    vectors++; if ({fwd_a, fwd_b} !== 4'b0100) begin miscompares++; $display("FAIL lu_fwd: got %b want 0100", {fwd_a, fwd_b}); end
    vectors++; if (ex_rd !== 5'd6) begin miscompares++; $display("FAIL lu_ex_rd: got %0d want 6", ex_rd); end
    drain();
  endtask

  task automatic test_branch_flush;
    drive(1'b1, C_BEQ, 5'd1, 5'd2, 5'd0); push(C_BEQ, 5'd0);
    tick();
    drive(1'b1, C_ADD, 5'd3, 5'd4, 5'd7); ex_branch_taken = 1'b1;
    #1;
    vectors++; if ({flush, stall} !== 2'b10) begin miscompares++; $display("FAIL br_flush: got %b want 10", {flush, stall}); end
    tick();
    ex_branch_taken = 1'b0;
    vectors++; if (ex_valid !== 1'b0) begin miscompares++; $display("FAIL br_squash: got %b want 0", ex_valid); end
    vectors++; if (flush_cnt !== 16'd1) begin miscompares++; $display("FAIL br_cnt: got %0d want 1", flush_cnt); end
    drive(1'b1, C_BEQ, 5'd1, 5'd2, 5'd0); push(C_BEQ, 5'd0);
    tick();
    drive(1'b1, C_ADD, 5'd3, 5'd4, 5'd7);
    #1;
    vectors++; if (flush !== 1'b0) begin miscompares++; $display("FAIL br_not_taken: got %b want 0", flush); end
    push(C_ADD, 5'd7);
    tick();
    vectors++; if ({ex_valid, ex_rd} !== {1'b1, 5'd7}) begin miscompares++; $display("FAIL br_keep: got %b/%0d want 1/7", ex_valid, ex_rd); end
    vectors++; if (flush_cnt !== 16'd1) begin miscompares++; $display("FAIL br_cnt_hold: got %0d want 1", flush_cnt); end
    drain();
  endtask

  task automatic test_forward;
    drive(1'b1, C_ADDI, 5'd0, 5'd0, 5'd3); push(C_ADDI, 5'd3); tick();
    drive(1'b1, C_ADD, 5'd1, 5'd2, 5'd3);  push(C_ADD, 5'd3);  tick();
    drive(1'b1, C_ADD, 5'd3, 5'd3, 5'd4);  push(C_ADD, 5'd4);  tick();
    drive(1'b0, '0, 5'd0, 5'd0, 5'd0); #1;
    vectors++; if ({fwd_a, fwd_b} !== 4'b1010) begin miscompares++; $display("FAIL fwd_mem_prio: got %b want 1010", {fwd_a, fwd_b}); end
    drain();
    drive(1'b1, C_ADDI, 5'd0, 5'd0, 5'd0); push(C_ADDI, 5'd0); tick();
    drive(1'b1, C_ADD, 5'd1, 5'd2, 5'd0);  push(C_ADD, 5'd0);  tick();
    drive(1'b1, C_ADD, 5'd0, 5'd0, 5'd4);  push(C_ADD, 5'd4);  tick();
    drive(1'b0, '0, 5'd0, 5'd0, 5'd0); #1;
    vectors++; if ({fwd_a, fwd_b} !== 4'b0000) begin miscompares++; $display("FAIL fwd_x0: got %b want 0000", {fwd_a, fwd_b}); end
    drain();
    drive(1'b1, C_ADD, 5'd1, 5'd2, 5'd5); push(C_ADD, 5'd5); tick();
    drive(1'b1, C_ADD, 5'd1, 5'd2, 5'd6); push(C_ADD, 5'd6); tick();
    drive(1'b1, C_ADD, 5'd5, 5'd6, 5'd7); push(C_ADD, 5'd7); tick();
    drive(1'b0, '0, 5'd0, 5'd0, 5'd0); #1;
    vectors++; if ({fwd_a, fwd_b} !== 4'b0110) begin miscompares++; $display("FAIL fwd_split: got %b want 0110", {fwd_a, fwd_b}); end
    drain();
  endtask

  task automatic test_jal_priority;
    drive(1'b1, C_JLD, 5'd0, 5'd0, 5'd5); push(C_JLD, 5'd5);
    tick();
    drive(1'b1, C_ADD, 5'd5, 5'd1, 5'd6);
    #1;
    vectors++; if ({flush, stall} !== 2'b10) begin miscompares++; $display("FAIL jal_prio: got %b want 10", {flush, stall}); end
    tick();
    vectors++; if (ex_valid !== 1'b0) begin miscompares++; $display("FAIL jal_squash: got %b want 0", ex_valid); end
    vectors++; if ({stall_cnt, flush_cnt} !== {16'd1, 16'd2}) begin miscompares++; $display("FAIL jal_cnt: got %0d/%0d want 1/2", stall_cnt, flush_cnt); end
    drain();
  endtask

  task automatic test_back_to_back;
    logic [4:0] b_rs1 [16];
    logic [4:0] b_rs2 [16];
    logic [4:0] b_rd  [16];
    logic       b_rw  [16];
    ctrl_t c;
    for (int i = 0; i <= 16; i++) begin
      if (i < 16) begin
        b_rs1[i] = 5'($urandom_range(0, 7));
        b_rs2[i] = 5'($urandom_range(0, 7));
        b_rd[i]  = 5'($urandom_range(0, 7));
        b_rw[i]  = 1'($urandom_range(0, 1));
        c = C_ADD; c.RegWrite = b_rw[i];
        drive(1'b1, c, b_rs1[i], b_rs2[i], b_rd[i]); push(c, b_rd[i]);
      end else begin
        drive(1'b0, '0, 5'd0, 5'd0, 5'd0);
      end
      #1;
      vectors++; if ({stall, flush} !== 2'b00) begin miscompares++; $display("FAIL b2b_hazard[%0d]: got %b want 00", i, {stall, flush}); end
      if (i >= 1) begin
        int j;
        logic [1:0] ea, eb;
        j = i - 1;
        ea = exp_fwd(b_rs1[j], j >= 1, (j >= 1) ? b_rw[j-1] : 1'b0, (j >= 1) ? b_rd[j-1] : 5'd0,
                     j >= 2, (j >= 2) ? b_rw[j-2] : 1'b0, (j >= 2) ? b_rd[j-2] : 5'd0);
        eb = exp_fwd(b_rs2[j], j >= 1, (j >= 1) ? b_rw[j-1] : 1'b0, (j >= 1) ? b_rd[j-1] : 5'd0,
                     j >= 2, (j >= 2) ? b_rw[j-2] : 1'b0, (j >= 2) ? b_rd[j-2] : 5'd0);
        vectors++;
        if ({fwd_a, fwd_b} !== {ea, eb}) begin
          miscompares++;
          $display("FAIL b2b_fwd[%0d]: got %b/%b want %b/%b", j, fwd_a, fwd_b, ea, eb);
        end
      end
      tick();
    end
    drain();
  endtask

  task automatic test_reset_mid_stall;
    drive(1'b1, C_LW, 5'd2, 5'd0, 5'd5); push(C_LW, 5'd5);
    tick();
    drive(1'b1, C_ADD, 5'd5, 5'd1, 5'd6);
    #1;
    vectors++; if (stall !== 1'b1) begin miscompares++; $display("FAIL mid_stall_pre: got %b want 1", stall); end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    sb.delete();
    vectors++; if ({ex_valid, mem_valid, wb_valid} !== 3'b000) begin miscompares++; $display("FAIL mid_rst_valid: got %b want 000", {ex_valid, mem_valid, wb_valid}); end
    vectors++; if ({stall_cnt, flush_cnt, s_stall_cnt} !== 34'd0) begin miscompares++; $display("FAIL mid_rst_cnt: got %0d/%0d/%0d want 0/0/0", stall_cnt, flush_cnt, s_stall_cnt); end
    vectors++; if (stall !== 1'b0) begin miscompares++; $display("FAIL mid_rst_stall: got %b want 0", stall); end
    drain();
  endtask

  task automatic test_saturation;
    for (int k = 0; k < 4; k++) begin
      logic [1:0] es;
      drive(1'b1, C_LW, 5'd2, 5'd0, 5'd5); push(C_LW, 5'd5);
      tick();
      drive(1'b1, C_ADD, 5'd5, 5'd1, 5'd6);
      #1;
      vectors++; if (stall !== 1'b1) begin miscompares++; $display("FAIL sat_stall[%0d]: got %b want 1", k, stall); end
      tick();
      push(C_ADD, 5'd6);
      tick();
      drive(1'b0, '0, 5'd0, 5'd0, 5'd0);
      tick();
      es = (k >= 2) ? 2'd3 : 2'(k + 1);
      vectors++; if (stall_cnt !== 16'(k + 1)) begin miscompares++; $display("FAIL sat_wide[%0d]: got %0d want %0d", k, stall_cnt, k + 1); end
      vectors++; if (s_stall_cnt !== es) begin miscompares++; $display("FAIL sat_narrow[%0d]: got %0d want %0d", k, s_stall_cnt, es); end
    end
    drain();
  endtask

  initial begin
    drive(1'b0, '0, 5'd0, 5'd0, 5'd0);
    ex_branch_taken = 1'b0;
    test_reset();
    test_load_use();
    test_branch_flush();
    test_forward();
    test_jal_priority();
    test_back_to_back();
    test_reset_mid_stall();
    test_saturation();
    drain();
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL sb_drain: %0d entries left, want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ctrl_pipe.md
CTRL_PIPE -- requirements
Module: ctrl_pipe

Interface
REQ-001 SHALL parameter CNT_W, default 16, width of each saturating event counter.
REQ-002 SHALL port clk  input  1  rising-edge clock for all state.
REQ-003 SHALL port rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL port id_valid  input  1  a decoded instruction is present in ID.
REQ-005 SHALL port id_ctrl  input  ctrl_t  decoder bundle {ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, ALUOp[1:0], Branch, JalSel, JalrSel}.
REQ-006 SHALL port id_rs1, id_rs2, id_rd  input  5 each  ID register indices.
REQ-007 SHALL port ex_branch_taken  input  1  EX comparator result for the instruction in EX.
REQ-008 SHALL port stall  output  1  hold PC and IF/ID this cycle.
REQ-009 SHALL port flush  output  1  squash IF/ID this cycle.
REQ-010 SHALL port ex_ctrl, mem_ctrl, wb_ctrl  output  ctrl_t  per-stage control.
REQ-011 SHALL port ex_valid, mem_valid, wb_valid  output  1 each  stage holds a live instruction.
REQ-012 SHALL port ex_rd, mem_rd, wb_rd  output  5 each  destination per stage.
REQ-013 SHALL port fwd_a, fwd_b  output  2 each  EX operand source: 00 regfile, 01 WB, 10 MEM.
REQ-014 SHALL port stall_cnt, flush_cnt  output  CNT_W each  event counters.

Function
REQ-015 SHALL, each edge with no stall and no flush, load EX<=ID (valid, ctrl, rs1, rs2, rd), MEM<=EX, WB<=MEM.
REQ-016 SHALL define bubble as valid=0, ctrl all zero, rd=0, rs1=rs2=0.
REQ-017 SHALL load a bubble into EX when id_valid=0.
REQ-018 SHALL assert stall combinationally when ex_valid & ex_ctrl.MemRead & ex_rd!=0 & (ex_rd==id_rs1 | ex_rd==id_rs2) & id_valid.
REQ-019 SHALL, on stall, load a bubble into EX while MEM and WB still advance; latency of the load-use penalty is exactly 1 cycle.
REQ-020 SHALL assert flush combinationally when ex_valid & (ex_ctrl.JalSel | (ex_ctrl.Branch & ex_branch_taken)).
REQ-021 SHALL, on flush, load a bubble into EX (ID instruction squashed); MEM and WB advance.
REQ-022 SHALL give flush priority: when both conditions hold, flush=1 and stall=0.
REQ-023 SHALL set fwd_a=10 when mem_valid & mem_ctrl.RegWrite & mem_rd!=0 & mem_rd==ex_rs1; else 01 when the same holds for WB; else 00. fwd_b identical on ex_rs2.
REQ-024 SHALL give MEM priority over WB when both match.
REQ-025 SHALL never forward from a MEM-stage load (mem_ctrl.MemRead=1) via 10; WB path covers it after stall.
REQ-026 SHALL increment stall_cnt on each cycle stall=1, flush_cnt on each cycle flush=1, both saturating at all-ones.
REQ-027 SHALL treat x0 (rd=0) as never a hazard or forwarding source.

Reset
REQ-028 SHALL, on clk edge with rst_n=0, put bubbles in EX, MEM, WB and clear both counters.
REQ-029 SHALL hold stall=0, flush=0, fwd_a=fwd_b=00 during and immediately after reset (follows from valid=0).
REQ-030 SHALL let reset mid-stall or mid-flush discard all in-flight instructions without side effects.

Structure
REQ-031 SHALL declare ctrl_t (packed struct, 10 bits) and FWD_RF/FWD_WB/FWD_MEM constants in shared package core_pkg, also used by the decoder.
REQ-032 SHALL contain one sub-module, hazard_unit, holding the stall, flush and forwarding combinational logic; ctrl_pipe holds the stage registers and counters.

Verification
REQ-033 SHALL cover: lw x5 in EX, ID add x6,x5,x1 -> stall=1 one cycle, EX bubble next cycle, then fwd_a=01, stall_cnt=1.
REQ-034 SHALL cover: beq in EX with ex_branch_taken=1 -> flush=1, next EX valid=0, flush_cnt=1; ex_branch_taken=0 -> flush=0.
REQ-035 SHALL cover: add x3 in MEM and addi x3 in WB, EX reads x3 as rs1 -> fwd_a=10; rd=0 in both -> fwd_a=00.
REQ-036 SHALL cover: jal in EX with simultaneous load-use condition -> flush=1, stall=0.
REQ-037 SHALL cover: rst_n=0 for one cycle during stall -> all valid=0, counters 0, stall=0 next cycle.
REQ-038 SHALL cover: CNT_W=2, four consecutive stalls -> stall_cnt holds 3.
